// File: rtl/fetch_pc_f_if.sv
// Fetch-stage bus: redirect and stall inputs from D and the hazard unit, fetch address, IF/ID outputs.
// exc_D exists only when FETCH_ADDR_EXC_EN is defined.
interface fetch_pc_f_if;
   logic        stall;
   logic [31:0] instr_F;
   logic        br_taken_D;
   logic [15:0] imm16_D;
   logic        j_en_D;
   logic [25:0] index26_D;
   logic        jr_en_D;
   logic [31:0] jr_target_D;
   logic [31:0] pc_F;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc8_D;
`ifdef FETCH_ADDR_EXC_EN
   logic        exc_D;
`endif

   modport master (
      input  stall, instr_F, br_taken_D, imm16_D, j_en_D, index26_D, jr_en_D, jr_target_D,
`ifdef FETCH_ADDR_EXC_EN
      output exc_D,
`endif
      output pc_F, instr_D, pc_D, pc8_D
   );

   modport slave (
      output stall, instr_F, br_taken_D, imm16_D, j_en_D, index26_D, jr_en_D, jr_target_D,
`ifdef FETCH_ADDR_EXC_EN
      input  exc_D,
`endif
      input  pc_F, instr_D, pc_D, pc8_D
   );
endinterface

// File: rtl/fetch_pc_f.sv
// Fetch sequencer: architectural PC, next-PC select with delay-slot semantics, IF/ID register.
// FETCH_ADDR_EXC_EN adds a fetch-address fault check that nops the instruction and raises exc_D.
module fetch_pc_f #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 4096
) (
   input logic           clk,
   input logic           reset,
   fetch_pc_f_if.master  bus
);
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
   } ifid_t;

   logic [31:0] pc_q, pc_next, br_target, j_target;
   ifid_t       ifid_q, ifid_d;

   // Branch and jump targets come from the D-stage PC, not the delay-slot PC in F.
   always_comb begin
      br_target = ifid_q.pc + 32'd4 + {{14{bus.imm16_D[15]}}, bus.imm16_D, 2'b00};
      j_target  = {ifid_q.pc[31:28], bus.index26_D, 2'b00};
      pc_next   = pc_q + 32'd4;
      if (bus.jr_en_D)         pc_next = bus.jr_target_D;
      else if (bus.j_en_D)     pc_next = j_target;
      else if (bus.br_taken_D) pc_next = br_target;
   end

`ifdef FETCH_ADDR_EXC_EN
   localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;
   logic [31:0] pc_off;
   logic        fault, exc_q;

   assign pc_off = pc_q - RESET_PC;
   assign fault  = (pc_q[1:0] != 2'b00) || ({1'b0, pc_off} >= IMEM_BYTES);

   always_comb begin
      ifid_d.instr = fault ? 32'd0 : bus.instr_F;
      ifid_d.pc    = pc_q;
      ifid_d.pc8   = pc_q + 32'd8;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           exc_q <= 1'b0;
      else if (!bus.stall) exc_q <= fault;
   end

   assign bus.exc_D = exc_q;
`else
   always_comb begin
      ifid_d.instr = bus.instr_F;
      ifid_d.pc    = pc_q;
      ifid_d.pc8   = pc_q + 32'd8;
   end
`endif

   // Stall freezes everything; redirects seen during stall are simply not applied.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ifid_q.instr <= 32'd0;
         ifid_q.pc    <= RESET_PC;
         ifid_q.pc8   <= RESET_PC + 32'd8;
      end else if (!bus.stall) begin
         pc_q   <= pc_next;
         ifid_q <= ifid_d;
      end
   end

   assign bus.pc_F    = pc_q;
   assign bus.instr_D = ifid_q.instr;
   assign bus.pc_D    = ifid_q.pc;
   assign bus.pc8_D   = ifid_q.pc8;
endmodule

// File: doc/fetch_pc_f.md
Name: fetch_pc_F

Overview:
- Fetch-stage sequencer for the 5-stage MIPS pipeline: holds the architectural PC, computes next-PC, and owns the IF/ID pipeline register.
- Drives the address of the word-indexed instruction memory (4096 words, index = addr[13:2]), samples the returned instruction combinationally in the same cycle, and latches {instr, pc} into D.
- Branch and jump decisions are resolved in D and fed back as redirects. The architectural branch delay slot is honoured, so a taken branch never flushes the fetched instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- IMEM_WORDS, 4096, instruction memory depth in words; used only by the optional range check.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  from hazard unit; freezes PC and IF/ID
- instr_F  input  32  instruction word returned by instruction memory for pc_F
- br_taken_D  input  1  conditional branch in D resolved taken
- imm16_D  input  16  branch offset field of instr_D
- j_en_D  input  1  j/jal in D
- index26_D  input  26  jump index field of instr_D
- jr_en_D  input  1  jr/jalr in D
- jr_target_D  input  32  forwarded rs value for jr/jalr
- pc_F  output  32  current fetch address, to instruction memory addr
- instr_D  output  32  IF/ID instruction
- pc_D  output  32  IF/ID PC
- pc8_D  output  32  pc_D + 8, link value for jal/jalr

Behaviour:
- Reset (async, any time, including mid-stall): pc_F = RESET_PC, instr_D = 0 (nop), pc_D = RESET_PC, pc8_D = RESET_PC + 8. The first cycle after release fetches RESET_PC.
- Next-PC priority, evaluated combinationally:
  - jr_en_D: jr_target_D
  - else j_en_D: {pc_D[31:28], index26_D, 2'b00}; region taken from pc_D, the delay-slot PC is not used.
  - else br_taken_D: pc_D + 4 + (sign_extend(imm16_D) << 2)
  - else: pc_F + 4
- Arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0. No overflow flag.
- Redirect inputs are honoured only when stall = 0. A stalled D instruction is not yet resolved, so redirects during stall are ignored.
- On a rising edge with stall = 0: pc_F <= next-PC; instr_D <= instr_F; pc_D <= pc_F; pc8_D <= pc_F + 8.
- On a rising edge with stall = 1: pc_F, instr_D, pc_D and pc8_D all hold. The memory is re-read at the same pc_F.
- Delay slot: in the cycle a taken redirect is applied, the instruction at pc_D + 4 (already at instr_F) is latched into D normally. No flush path exists.
- Latency: instruction at address A appears on instr_D one edge after pc_F = A with stall low.
- Simultaneous redirects (for example jr_en_D and br_taken_D both high) are a decoder error. Priority above still applies deterministically.
- jr_target_D is not realigned. A misaligned target passes to pc_F unchanged, except when the optional feature is compiled in.

Optional Feature:
- Macro: FETCH_ADDR_EXC_EN.
- Defined: adds output exc_D (1 bit, registered with IF/ID, reset 0).
- A fetch is faulting when pc_F[1:0] != 0, or when (pc_F - RESET_PC) >= IMEM_WORDS*4.
- On a faulting fetch: instr_D <= 0 (nop), exc_D <= 1, pc_D <= the faulting pc_F, and next-PC logic is unchanged.
- exc_D holds under stall and clears on the next non-faulting capture.
- Undefined: no exc_D port; instr_F is always captured as is.

Test Plan:
- Reset release, stall = 0, memory returns word index as data: pc_F steps 0, 4, 8, 12; instr_D lags by one edge with values 0, 1, 2; pc8_D = pc_D + 8.
- beq in D at pc_D = 0x10, br_taken_D = 1, imm16_D = 0xFFFC: the delay-slot word at 0x14 is latched into D, and the next pc_F = 0x04.
- j_en_D = 1, index26_D = 0x0000100, pc_D = 0x2000_0020: next pc_F = 0x2000_0400; same-cycle jr_en_D = 1 with jr_target_D = 0x80 overrides it to 0x80.
- stall held 3 cycles with br_taken_D = 1: pc_F, instr_D and pc_D stay constant. On stall release, the redirect is applied on the first edge.
- Reset asserted asynchronously mid-stall at pc_F = 0x40: all outputs return to reset values immediately, without waiting for a clock edge.
- With FETCH_ADDR_EXC_EN, jr_target_D = 0x42: after one edge pc_F = 0x42; after the next edge exc_D = 1, instr_D = 0, pc_D = 0x42.
